// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display constants, FSM states and pipeline record
package display_pkg;

    localparam int         H_ACTIVE         = 640;
    localparam int         V_ACTIVE         = 480;
    localparam logic [3:0] BG_COLOR_DEFAULT = 4'h5;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_e;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic paint;
    } timing_t;

endpackage

// File: rtl/scale_step_counter.sv
// rtl/scale_step_counter.sv - sub-count modulo modulus_p feeding an index counter
// Clear has priority over step; wrap_o pulses on the step that rolls sub_o over.
module scale_step_counter #(
    parameter  int modulus_p   = 4,
    parameter  int idx_width_p = 8,
    localparam int sub_width_p = (modulus_p > 1) ? $clog2(modulus_p) : 1
) (
    input  logic                   clk_pix_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   step_i,
    output logic [sub_width_p-1:0] sub_o,
    output logic [idx_width_p-1:0] idx_o,
    output logic                   wrap_o
);

    logic [sub_width_p-1:0] sub_q, sub_d;
    logic [idx_width_p-1:0] idx_q, idx_d;
    logic                   at_top;

    assign at_top = (sub_q == sub_width_p'(modulus_p - 1));

    always_comb begin
        sub_d  = sub_q;
        idx_d  = idx_q;
        wrap_o = 1'b0;
        if (clear_i) begin
            sub_d = '0;
            idx_d = '0;
        end else if (step_i) begin
            if (at_top) begin
                sub_d  = '0;
                idx_d  = idx_q + 1'b1;
                wrap_o = 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pix_i) begin
        if (reset_i) begin
            sub_q <= '0;
            idx_q <= '0;
        end else begin
            sub_q <= sub_d;
            idx_q <= idx_d;
        end
    end

    assign sub_o = sub_q;
    assign idx_o = idx_q;

endmodule

// File: rtl/sobel_display_scaler.sv
// rtl/sobel_display_scaler.sv - raster-driven frame-RAM reader with integer pixel replication
// Address = line_base + src_x, built from counters only; outputs have a fixed 3-cycle latency.
module sobel_display_scaler
    import display_pkg::*;
#(
    parameter int         img_width_p  = 158,
    parameter int         img_height_p = 118,
    parameter int         scale_p      = 4,
    parameter int         addr_width_p = 15,
    parameter logic [3:0] bg_color_p   = BG_COLOR_DEFAULT
) (
    input  logic                    clk_pix_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic signed [15:0]      sx_i,
    input  logic signed [15:0]      sy_i,
    input  logic                    hsync_i,
    input  logic                    vsync_i,
    input  logic                    de_i,
    input  logic                    frame_i,
    output logic [addr_width_p-1:0] rd_addr_o,
    output logic                    rd_en_o,
    input  logic [3:0]              rd_data_i,
    output logic                    hsync_o,
    output logic                    vsync_o,
    output logic                    de_o,
    output logic [3:0]              pixel_o,
    output logic                    active_o
);

    localparam int PAINT_W = img_width_p * scale_p;
    localparam int PAINT_H = img_height_p * scale_p;
    localparam int SUB_W   = (scale_p > 1) ? $clog2(scale_p) : 1;
    localparam int X_IDX_W = $clog2(img_width_p + 1);
    localparam int Y_IDX_W = $clog2(img_height_p + 1);

    if (PAINT_W > H_ACTIVE || PAINT_H > V_ACTIVE) begin : g_bad_size
        $fatal(1, "sobel_display_scaler: scaled image exceeds the active display area");
    end
    if (scale_p < 1 || scale_p > 4) begin : g_bad_scale
        $fatal(1, "sobel_display_scaler: scale_p must be 1..4");
    end
    if ((2 ** addr_width_p) < img_width_p * img_height_p) begin : g_bad_addr
        $fatal(1, "sobel_display_scaler: addr_width_p too small for the image");
    end

    state_e                  state_q, state_d;
    logic                    in_paint, last_x, read_go, base_adv;
    logic                    rd_en_q, rd_en_d;
    logic [addr_width_p-1:0] rd_addr_q, rd_addr_d;
    logic [addr_width_p-1:0] line_base_q, line_base_d;
    timing_t [1:0]           pipe_q, pipe_d;
    logic                    hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [3:0]              pixel_q, pixel_d;

    logic [SUB_W-1:0]        sub_x, sub_y;
    logic [X_IDX_W-1:0]      src_x;
    logic [Y_IDX_W-1:0]      src_y;
    logic                    x_wrap, y_wrap;
    logic                    unused_cnt;

    assign in_paint = (int'(sx_i) >= 0) && (int'(sx_i) < PAINT_W) &&
                      (int'(sy_i) >= 0) && (int'(sy_i) < PAINT_H);
    assign last_x   = (int'(sx_i) == PAINT_W - 1);
    // Gating on enable_i too means the read stops in the same cycle the FSM leaves RUN.
    assign read_go  = (state_q == RUN) && enable_i && in_paint;
    // Past the last source line the base is left alone so it never points beyond the image.
    assign base_adv = y_wrap && (src_y != Y_IDX_W'(img_height_p - 1));

    scale_step_counter #(
        .modulus_p  (scale_p),
        .idx_width_p(X_IDX_W)
    ) u_x_counter (
        .clk_pix_i(clk_pix_i),
        .reset_i  (reset_i),
        .clear_i  (frame_i || (read_go && last_x)),
        .step_i   (read_go),
        .sub_o    (sub_x),
        .idx_o    (src_x),
        .wrap_o   (x_wrap)
    );

    scale_step_counter #(
        .modulus_p  (scale_p),
        .idx_width_p(Y_IDX_W)
    ) u_y_counter (
        .clk_pix_i(clk_pix_i),
        .reset_i  (reset_i),
        .clear_i  (frame_i),
        .step_i   (read_go && last_x),
        .sub_o    (sub_y),
        .idx_o    (src_y),
        .wrap_o   (y_wrap)
    );

    assign unused_cnt = ^{sub_x, sub_y, x_wrap};

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (frame_i) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        line_base_d = line_base_q;
        if (frame_i) begin
            line_base_d = '0;
        end else if (base_adv) begin
            line_base_d = line_base_q + addr_width_p'(img_width_p);
        end

        rd_en_d   = read_go;
        rd_addr_d = read_go ? (line_base_q + addr_width_p'(src_x)) : rd_addr_q;

        pipe_d[0] = '{hsync: hsync_i, vsync: vsync_i, de: de_i, paint: read_go};
        pipe_d[1] = pipe_q[0];

        hsync_d = pipe_q[1].hsync;
        vsync_d = pipe_q[1].vsync;
        de_d    = pipe_q[1].de;
        if (pipe_q[1].paint) begin
            pixel_d = rd_data_i;
        end else if (pipe_q[1].de) begin
            pixel_d = bg_color_p;
        end else begin
            pixel_d = 4'h0;
        end
    end

    always_ff @(posedge clk_pix_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            line_base_q <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pipe_q      <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            pixel_q     <= 4'h0;
        end else begin
            state_q     <= state_d;
            line_base_q <= line_base_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            pipe_q      <= pipe_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            pixel_q     <= pixel_d;
        end
    end

    assign rd_addr_o = rd_addr_q;
    assign rd_en_o   = rd_en_q;
    assign hsync_o   = hsync_q;
    assign vsync_o   = vsync_q;
    assign de_o      = de_q;
    assign pixel_o   = pixel_q;
    assign active_o  = (state_q == RUN);

endmodule

// File: tb/tb_sobel_display_scaler.sv
// tb/tb_sobel_display_scaler.sv - scoreboard bench driving a compressed raster into two scaler instances
// Instance 0 uses scale 3, instance 1 scale 1; both see identical timing and enable stimulus.
module tb_sobel_display_scaler;

    localparam int         IMG_W = 20;
    localparam int         IMG_H = 6;
    localparam int         AW    = 15;
    localparam logic [3:0] BG    = 4'h5;
    localparam int         HS    = -8;
    localparam int         HE    = 71;
    localparam int         VS    = -3;
    localparam int         VE    = 21;
    localparam int         DE_W  = 64;
    localparam int         DE_H  = 20;

    function automatic int scale_of(input int g);
        return (g == 0) ? 3 : 1;
    endfunction

    logic               clk_pix  = 1'b0;
    logic               reset_i  = 1'b1;
    logic               enable_i = 1'b0;
    logic signed [15:0] sx_i     = '0;
    logic signed [15:0] sy_i     = '0;
    logic               hsync_i  = 1'b0;
    logic               vsync_i  = 1'b0;
    logic               de_i     = 1'b0;
    logic               frame_i  = 1'b0;

    logic [1:0][AW-1:0] rd_addr_w;
    logic [1:0]         rd_en_w, hsync_w, vsync_w, de_w, active_w;
    logic [1:0][3:0]    rd_data_w, pixel_w;

    always #5 clk_pix = ~clk_pix;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sobel_display_scaler #(
            .img_width_p (IMG_W),
            .img_height_p(IMG_H),
            .scale_p     (scale_of(g)),
            .addr_width_p(AW),
            .bg_color_p  (BG)
        ) u_dut (
            .clk_pix_i(clk_pix),
            .reset_i  (reset_i),
            .enable_i (enable_i),
            .sx_i     (sx_i),
            .sy_i     (sy_i),
            .hsync_i  (hsync_i),
            .vsync_i  (vsync_i),
            .de_i     (de_i),
            .frame_i  (frame_i),
            .rd_addr_o(rd_addr_w[g]),
            .rd_en_o  (rd_en_w[g]),
            .rd_data_i(rd_data_w[g]),
            .hsync_o  (hsync_w[g]),
            .vsync_o  (vsync_w[g]),
            .de_o     (de_w[g]),
            .pixel_o  (pixel_w[g]),
            .active_o (active_w[g])
        );
    end

    // Frame RAM stand-in: each word holds the low nibble of its own address.
    always @(posedge clk_pix) rd_data_w <= {rd_addr_w[1][3:0], rd_addr_w[0][3:0]};

    int cyc = 0;
    always @(posedge clk_pix) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          g;
        logic        en;
        logic        act;
        logic [AW-1:0] addr;
    } rd_exp_t;

    typedef struct {
        int         due;
        int         g;
        logic [2:0] tim;
        logic [3:0] px;
    } px_exp_t;

    rd_exp_t rd_q[$];
    px_exp_t px_q[$];
    int      errors = 0;
    int      checks = 0;
    bit      running_m [2];
    bit      armed_m   [2];
    int      max_addr  [2];

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", name, g, cyc, act, exp);
        end
    endtask

    // Issue one raster sample and queue what each instance must show 1 and 3 cycles later.
    task automatic drive(input int sx, input int sy, input logic en);
        logic       de, paint, rd;
        int         s, addr;
        logic [3:0] pxv;
        sx_i     = 16'(sx);
        sy_i     = 16'(sy);
        enable_i = en;
        hsync_i  = (sx >= -6) && (sx < -3);
        vsync_i  = (sy >= -2) && (sy < 0);
        de       = (sx >= 0) && (sx < DE_W) && (sy >= 0) && (sy < DE_H);
        de_i     = de;
        frame_i  = (sx == -1) && (sy == 0);
        for (int g = 0; g < 2; g++) begin
            s     = scale_of(g);
            paint = (sx >= 0) && (sx < IMG_W * s) && (sy >= 0) && (sy < IMG_H * s);
            rd    = running_m[g] && en && paint;
            addr  = (sy / s) * IMG_W + (sx / s);
            if (!en) begin
                running_m[g] = 1'b0;
                armed_m[g]   = 1'b0;
            end else if (!running_m[g]) begin
                running_m[g] = armed_m[g] && frame_i;
                armed_m[g]   = 1'b1;
            end
            pxv = rd ? 4'(addr) : (de ? BG : 4'h0);
            rd_q.push_back(rd_exp_t'{due: cyc + 1, g: g, en: rd, act: running_m[g], addr: AW'(addr)});
            px_q.push_back(px_exp_t'{due: cyc + 3, g: g, tim: {hsync_i, vsync_i, de}, px: pxv});
        end
        @(negedge clk_pix);
    endtask

    task automatic frame(input logic en0, input int tog_y, input int tog_x);
        logic en;
        en = en0;
        for (int y = VS; y <= VE; y++) begin
            for (int x = HS; x <= HE; x++) begin
                if (y == tog_y && x == tog_x) en = ~en;
                drive(x, y, en);
            end
        end
    endtask

    initial begin
        rd_exp_t re;
        px_exp_t pe;
        forever begin
            @(negedge clk_pix);
            if (!reset_i) begin
                while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                    re = rd_q.pop_front();
                    check("rd_en", re.g, 32'(rd_en_w[re.g]), 32'(re.en));
                    check("active", re.g, 32'(active_w[re.g]), 32'(re.act));
                    if (re.en) begin
                        check("rd_addr", re.g, 32'(rd_addr_w[re.g]), 32'(re.addr));
                        if (int'(rd_addr_w[re.g]) > max_addr[re.g]) max_addr[re.g] = int'(rd_addr_w[re.g]);
                    end
                end
                while (px_q.size() > 0 && px_q[0].due <= cyc) begin
                    pe = px_q.pop_front();
                    check("hs_vs_de", pe.g, 32'({hsync_w[pe.g], vsync_w[pe.g], de_w[pe.g]}), 32'(pe.tim));
                    check("pixel", pe.g, 32'(pixel_w[pe.g]), 32'(pe.px));
                end
            end
        end
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            running_m[g] = 1'b0;
            armed_m[g]   = 1'b0;
            max_addr[g]  = -1;
        end
        reset_i  = 1'b1;
        enable_i = 1'b1;
        frame_i  = 1'b1;
        de_i     = 1'b1;
        hsync_i  = 1'b1;
        vsync_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_pix);
            for (int g = 0; g < 2; g++) begin
                check("reset_outs", g,
                      32'({rd_en_w[g], active_w[g], hsync_w[g], vsync_w[g], de_w[g], pixel_w[g], rd_addr_w[g]}),
                      32'(0));
            end
        end
        reset_i = 1'b0;

        frame(1'b0, 99, 0);
        frame(1'b0, 99, 0);
        frame(1'b0, 5, 10);
        frame(1'b1, 99, 0);
        frame(1'b1, $urandom_range(1, 16), $urandom_range(0, 59));
        frame(1'b0, 0, -1);
        frame(1'b1, 99, 0);
        for (int f = 0; f < 4; f++) begin
            frame(1'($urandom_range(0, 1)), $urandom_range(0, VE - VS) + VS, $urandom_range(0, HE - HS) + HS);
        end
        frame(1'b1, 99, 0);

        repeat (5) @(negedge clk_pix);
        #1;
        check("drain", 0, 32'(rd_q.size() + px_q.size()), 32'(0));
        for (int g = 0; g < 2; g++) begin
            check("max_addr", g, 32'(max_addr[g]), 32'(IMG_W * IMG_H - 1));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
